// File: rtl/sdram_cmd_fsm.sv
// SDRAM command sequencer: ACTIVE/READ/WRITE/PRECHARGE/AUTO REFRESH with parameterised waits.
// Define SDRAM_AUTO_PRECHARGE_EN to use READ/WRITE with auto-precharge instead of an explicit PRECHARGE.
module sdram_cmd_fsm #(
    parameter int unsigned TRCD = 2,
    parameter int unsigned CL   = 3,
    parameter int unsigned TWR  = 2,
    parameter int unsigned TRP  = 2,
    parameter int unsigned TRFC = 7
) (
    input  logic       clk_100m,
    input  logic       rst_n,
    input  logic       init_done,
    input  logic       ref_req,
    input  logic       wr_req,
    input  logic       rd_req,
    output logic [3:0] work_state,
    output logic [3:0] sdram_cmd,
    output logic       sdram_a10,
    output logic       ref_ack,
    output logic       wr_ack,
    output logic       rd_ack
);

    typedef enum logic [3:0] {
        W_IDLE   = 4'd0,
        W_ACTIVE = 4'd1,
        W_TRCD   = 4'd2,
        W_READ   = 4'd3,
        W_CL     = 4'd4,
        W_RD     = 4'd5,
        W_WD     = 4'd6,
        W_TWR    = 4'd7,
        W_PRE    = 4'd8,
        W_TRP    = 4'd9,
        W_AR     = 4'd10,
        W_TRFC   = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_REF  = 2'd1,
        OP_WR   = 2'd2,
        OP_RD   = 2'd3
    } op_t;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_AREF  = 4'b0001;

`ifdef SDRAM_AUTO_PRECHARGE_EN
    localparam logic AUTO_PRE = 1'b1;
`else
    localparam logic AUTO_PRE = 1'b0;
`endif

    state_t     state, next_state;
    op_t        op, next_op;
    logic [3:0] cnt, next_cnt;
    logic [2:0] next_ack;
    logic       any_ack;

    function automatic logic [3:0] cmd_of(input state_t s);
        case (s)
            W_ACTIVE: cmd_of = CMD_ACT;
            W_READ:   cmd_of = CMD_READ;
            W_WD:     cmd_of = CMD_WRITE;
            W_PRE:    cmd_of = CMD_PRE;
            W_AR:     cmd_of = CMD_AREF;
            default:  cmd_of = CMD_NOP;
        endcase
    endfunction

    assign any_ack    = ref_ack | wr_ack | rd_ack;
    assign work_state = state;

    always_comb begin
        next_state = state;
        next_op    = op;
        next_cnt   = cnt;
        next_ack   = '0;
        case (state)
            W_IDLE: begin
                next_cnt = '0;
                if (init_done && !any_ack) begin
                    if (ref_req) begin
                        next_state = W_AR;
                        next_op    = OP_REF;
                    end else if (wr_req) begin
                        next_state = W_ACTIVE;
                        next_op    = OP_WR;
                    end else if (rd_req) begin
                        next_state = W_ACTIVE;
                        next_op    = OP_RD;
                    end
                end
            end
            W_ACTIVE: begin
                next_state = W_TRCD;
                next_cnt   = 4'(TRCD - 1);
            end
            W_TRCD: begin
                if (cnt == '0) next_state = (op == OP_WR) ? W_WD : W_READ;
                else           next_cnt   = cnt - 4'd1;
            end
            W_WD: begin
                next_state = W_TWR;
                next_cnt   = 4'(TWR - 1);
            end
            W_TWR: begin
                if (cnt != '0) begin
                    next_cnt = cnt - 4'd1;
                end else if (AUTO_PRE) begin
                    next_state = W_TRP;
                    next_cnt   = 4'(TRP - 1);
                end else begin
                    next_state = W_PRE;
                end
            end
            // W_CL lasts CL-1 cycles so W_RD lands exactly CL cycles after READ.
            W_READ: begin
                next_state = W_CL;
                next_cnt   = 4'(CL - 2);
            end
            W_CL: begin
                if (cnt == '0) next_state = W_RD;
                else           next_cnt   = cnt - 4'd1;
            end
            W_RD: begin
                if (AUTO_PRE) begin
                    next_state = W_TRP;
                    next_cnt   = 4'(TRP - 1);
                end else begin
                    next_state = W_PRE;
                end
            end
            W_PRE: begin
                next_state = W_TRP;
                next_cnt   = 4'(TRP - 1);
            end
            W_TRP, W_TRFC: begin
                if (cnt == '0) begin
                    next_state = W_IDLE;
                    next_op    = OP_NONE;
                    next_ack   = {op == OP_REF, op == OP_WR, op == OP_RD};
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            W_AR: begin
                next_state = W_TRFC;
                next_cnt   = 4'(TRFC - 1);
            end
            default: begin
                next_state = W_IDLE;
                next_op    = OP_NONE;
                next_cnt   = '0;
            end
        endcase
    end

    // Outputs are decoded from next_state so they line up with the registered state.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= W_IDLE;
            op        <= OP_NONE;
            cnt       <= '0;
            sdram_cmd <= CMD_NOP;
            sdram_a10 <= 1'b0;
            ref_ack   <= 1'b0;
            wr_ack    <= 1'b0;
            rd_ack    <= 1'b0;
        end else begin
            state     <= next_state;
            op        <= next_op;
            cnt       <= next_cnt;
            sdram_cmd <= cmd_of(next_state);
            sdram_a10 <= (next_state == W_PRE) ||
                         (AUTO_PRE && (next_state == W_READ || next_state == W_WD));
            ref_ack   <= next_ack[2];
            wr_ack    <= next_ack[1];
            rd_ack    <= next_ack[0];
        end
    end

endmodule

// File: doc/sdram_cmd_fsm.md
SDRAM_CMD_FSM -- requirements
Module: sdram_cmd_fsm

Interface
REQ-001 SHALL have parameter TRCD, default 2, meaning ACTIVE-to-READ/WRITE wait in cycles (legal 1..15).
REQ-002 SHALL have parameter CL, default 3, meaning CAS latency in cycles (legal 2..3).
REQ-003 SHALL have parameter TWR, default 2, meaning write-recovery wait in cycles (legal 1..15).
REQ-004 SHALL have parameter TRP, default 2, meaning PRECHARGE wait in cycles (legal 1..15).
REQ-005 SHALL have parameter TRFC, default 7, meaning AUTO REFRESH wait in cycles (legal 1..15).
REQ-006 SHALL have the ports: clk_100m input 1 system clock; rst_n input 1 reset.
REQ-007 SHALL have the ports: init_done input 1 power-up init complete; ref_req input 1 refresh request (level); wr_req input 1 write request (level); rd_req input 1 read request (level).
REQ-008 SHALL have the ports: work_state output 4 current state, consumed by the data-path stage; sdram_cmd output 4 {cs_n,ras_n,cas_n,we_n}; sdram_a10 output 1 auto-precharge/all-bank bit.
REQ-009 SHALL have the ports: ref_ack output 1; wr_ack output 1; rd_ack output 1, each a one-cycle completion pulse.
REQ-010 SHALL use one clock, clk_100m; rst_n SHALL be asynchronous and active-low.

Function
REQ-011 SHALL encode work_state as W_IDLE=0, W_ACTIVE=1, W_TRCD=2, W_READ=3, W_CL=4, W_RD=5, W_WD=6, W_TWR=7, W_PRE=8, W_TRP=9, W_AR=10, W_TRFC=11; codes 12-15 SHALL return to W_IDLE next cycle.
REQ-012 SHALL decode sdram_cmd from the current state: W_ACTIVE=0011, W_READ=0101, W_WD=0100, W_PRE=0010, W_AR=0001, all other states NOP=0111.
REQ-013 SHALL drive sdram_a10=1 in W_PRE; in all other states it SHALL be 0 unless REQ-026 applies.
REQ-014 SHALL hold W_IDLE while init_done=0, ignoring all requests.
REQ-015 SHALL sample requests only in W_IDLE, with priority ref_req > wr_req > rd_req; the other requests SHALL wait.
REQ-016 SHALL NOT sample requests in the W_IDLE cycle in which any ack is high.
REQ-017 Write path SHALL be W_ACTIVE(1) -> W_TRCD(TRCD) -> W_WD(1) -> W_TWR(TWR) -> W_PRE(1) -> W_TRP(TRP) -> W_IDLE.
REQ-018 Read path SHALL be W_ACTIVE(1) -> W_TRCD(TRCD) -> W_READ(1) -> W_CL(CL-1) -> W_RD(1) -> W_PRE(1) -> W_TRP(TRP) -> W_IDLE, so that W_RD falls exactly CL cycles after the READ command.
REQ-019 Refresh path SHALL be W_AR(1) -> W_TRFC(TRFC) -> W_IDLE.
REQ-020 SHALL time each wait with a 4-bit down-counter, loaded on state entry and exiting at terminal count.
REQ-021 SHALL pulse the matching ack for exactly one cycle, registered, in the first W_IDLE cycle after completion of the path.
REQ-022 Requests deasserted mid-path SHALL NOT abort the path; the ack SHALL still be issued.

Reset
REQ-023 While rst_n=0, SHALL immediately force work_state=W_IDLE, sdram_cmd=0111, sdram_a10=0, all acks 0 and counter 0, including mid-path.
REQ-024 After rst_n rises, SHALL restart from W_IDLE and issue no ack for the interrupted path.

Configuration
REQ-025 Macro SDRAM_AUTO_PRECHARGE_EN SHALL select the auto-precharge behaviour.
REQ-026 With SDRAM_AUTO_PRECHARGE_EN defined, SHALL drive sdram_a10=1 in W_READ and W_WD, and W_TWR and W_RD SHALL go directly to W_TRP, so W_PRE is never entered.
REQ-027 Without SDRAM_AUTO_PRECHARGE_EN, SHALL behave exactly as REQ-013, REQ-017 and REQ-018.

Verification
REQ-028 Bench SHALL cover: defaults, init_done=1, wr_req held from idle cycle 0 -> ACT@1, WRITE@4 (work_state=6), PRE@7 with a10=1, wr_ack@10 only.
REQ-029 Bench SHALL cover: defaults, rd_req from cycle 0 -> READ@4, work_state=W_RD@7, PRE@8, rd_ack@11.
REQ-030 Bench SHALL cover: ref_req, wr_req and rd_req all raised together -> AREF@1, ref_ack@9; write path then starts after the ack cycle, followed by the read path.
REQ-031 Bench SHALL cover: init_done=0 with all requests high for 20 cycles -> sdram_cmd=0111 and work_state=0 throughout.
REQ-032 Bench SHALL cover: rst_n pulled low during W_TWR -> same-cycle W_IDLE and NOP; no wr_ack after release.
REQ-033 Bench SHALL cover: SDRAM_AUTO_PRECHARGE_EN defined, write -> WRITE@4 with a10=1, no PRE command, wr_ack@9.
